// File: rtl/clac_seq.sv
// Registered calculator: single-cycle logic/add/sub/shift ops and a DW-step
// iterative shift-add multiply, with a one-cycle done pulse per completed op.
module clac_seq #(
    parameter int DW = 16
) (
    input  logic            hclk_i,
    input  logic            hreset_i,
    input  logic            ctrl_i,
    input  logic [2:0]      clac_mode_i,
    input  logic [DW-1:0]   opcode_a_i,
    input  logic [DW-1:0]   opcode_b_i,
    input  logic            clr_i,
    output logic [2*DW-1:0] result_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            zero_o
);

    // state  | meaning
    // S_IDLE | waiting for an op; single-cycle ops complete here
    // S_MUL  | iterative multiply, one shift-add step per edge
    localparam int SW = $clog2(DW);
    localparam int RW = 2 * DW;

    localparam logic [2:0] MODE_AND = 3'b000;
    localparam logic [2:0] MODE_OR  = 3'b001;
    localparam logic [2:0] MODE_XOR = 3'b010;
    localparam logic [2:0] MODE_ADD = 3'b011;
    localparam logic [2:0] MODE_SUB = 3'b100;
    localparam logic [2:0] MODE_MUL = 3'b101;
    localparam logic [2:0] MODE_SHL = 3'b110;
    localparam logic [2:0] MODE_SHR = 3'b111;

    localparam logic [SW-1:0] CNT_LAST = SW'(DW - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   result_q;
    logic            done_q;
    logic            busy_q;
    logic            zero_q;
    logic [SW-1:0]   cnt_q;
    logic [RW-1:0]   mcand_q;
    logic [DW-1:0]   mplier_q;
    logic [RW-1:0]   acc_q;

    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [SW-1:0]   shamt;
    logic [RW-1:0]   alu_d;
    logic [RW-1:0]   acc_d;
    logic            accept;

    assign a_ext  = {{DW{1'b0}}, opcode_a_i};
    assign b_ext  = {{DW{1'b0}}, opcode_b_i};
    assign shamt  = opcode_b_i[SW-1:0];
    assign accept = ctrl_i && !busy_q;

    always_comb begin
        alu_d = '0;
        unique case (clac_mode_i)
            MODE_AND: alu_d = a_ext & b_ext;
            MODE_OR:  alu_d = a_ext | b_ext;
            MODE_XOR: alu_d = a_ext ^ b_ext;
            MODE_ADD: alu_d = a_ext + b_ext;
            MODE_SUB: alu_d = a_ext - b_ext;
            MODE_SHL: alu_d = a_ext << shamt;
            MODE_SHR: alu_d = a_ext >> shamt;
            default:  alu_d = '0;
        endcase
    end

    // Multiplicand is pre-shifted each step, so the current multiplier LSB
    // always selects the correctly weighted partial product.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (clr_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (clac_mode_i == MODE_MUL) begin
                            mcand_q  <= a_ext;
                            mplier_q <= opcode_b_i;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_clac_seq.sv
// Self-checking bench for clac_seq: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the calculator.
module tb_clac_seq;

    localparam int DW = 16;
    localparam int RW = 2 * DW;

    logic          clk;
    logic          hreset;
    logic          ctrl;
    logic [2:0]    mode;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          clr;
    logic [RW-1:0] result;
    logic          done;
    logic          busy;
    logic          zero;

    int n_checks = 0;
    int n_errors = 0;

    clac_seq #(.DW(DW)) dut (
        .hclk_i      (clk),
        .hreset_i    (hreset),
        .ctrl_i      (ctrl),
        .clac_mode_i (mode),
        .opcode_a_i  (op_a),
        .opcode_b_i  (op_b),
        .clr_i       (clr),
        .result_o    (result),
        .done_o      (done),
        .busy_o      (busy),
        .zero_o      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] ref_op(input logic [2:0] m, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        int            sh;
        ax = RW'(a);
        bx = RW'(b);
        sh = int'(b) % DW;
        case (m)
            3'd0:    return ax & bx;
            3'd1:    return ax | bx;
            3'd2:    return ax ^ bx;
            3'd3:    return ax + bx;
            3'd4:    return ax - bx;
            3'd5:    return ax * bx;
            3'd6:    return ax << sh;
            default: return ax >> sh;
        endcase
    endfunction

    task automatic drive(input logic c, input logic [2:0] m, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        ctrl = c;
        mode = m;
        op_a = a;
        op_b = b;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        clr    = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        tick();
        tick();
        n_checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
            n_errors++;
            $display("FAIL reset: result=%h done=%b busy=%b zero=%b, want 0 0 0 1",
                     result, done, busy, zero);
        end
        hreset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_hold[%0d]: result=%h done=%b busy=%b zero=%b, want 0 0 0 1",
                         i, result, done, busy, zero);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]    m[3];
        logic [DW-1:0] a[3];
        logic [DW-1:0] b[3];
        logic [RW-1:0] want[3];
        m = '{3'd0, 3'd3, 3'd2};
        a = '{16'hF0F0, 16'hFFFF, 16'hAAAA};
        b = '{16'hFF00, 16'h0001, 16'hAAAA};
        want = '{32'h0000F000, 32'h00010000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, m[i], a[i], b[i]);
            tick();
            n_checks++;
            if (result !== want[i] || done !== 1'b1 || zero !== (want[i] == '0)) begin
                n_errors++;
                $display("FAIL b2b[%0d]: result=%h done=%b zero=%b, want %h 1 %b",
                         i, result, done, zero, want[i], want[i] == '0);
            end
        end
        drive(1'b0, 3'd0, 16'h1234, 16'h5678);
        tick();
        n_checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            n_errors++;
            $display("FAIL b2b_end: done=%b result=%h, want 0 00000000", done, result);
        end
    endtask

    task automatic test_sub_shift();
        logic [2:0]    m[3];
        logic [DW-1:0] a[3];
        logic [DW-1:0] b[3];
        logic [RW-1:0] want[3];
        m = '{3'd4, 3'd6, 3'd7};
        a = '{16'h0003, 16'h8001, 16'h8001};
        b = '{16'h0005, 16'h000F, 16'h0013};
        want = '{32'hFFFFFFFE, 32'h40008000, 32'h00001000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, m[i], a[i], b[i]);
            tick();
            drive(1'b0, 3'd0, '0, '0);
            n_checks++;
            if (result !== want[i] || done !== 1'b1 || zero !== 1'b0) begin
                n_errors++;
                $display("FAIL sub_shift[%0d]: result=%h done=%b zero=%b, want %h 1 0",
                         i, result, done, zero, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_mul();
        logic [RW-1:0] prev;
        prev = result;
        drive(1'b1, 3'd5, 16'hFFFF, 16'hFFFF);
        tick();
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || result !== prev) begin
                n_errors++;
                $display("FAIL mul_busy[%0d]: busy=%b done=%b result=%h, want 1 0 %h",
                         i, busy, done, result, prev);
            end
            if (i == 4 || i == DW - 1) drive(1'b1, 3'd0, 16'h0F0F, 16'h00FF);
            else drive(1'b0, 3'd5, $urandom(), $urandom());
            tick();
        end
        drive(1'b0, 3'd0, '0, '0);
        n_checks++;
        if (result !== 32'hFFFE0001 || done !== 1'b1 || busy !== 1'b0 || zero !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_done: result=%h done=%b busy=%b zero=%b, want fffe0001 1 0 0",
                     result, done, busy, zero);
        end
        tick();
        n_checks++;
        if (result !== 32'hFFFE0001 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_after: result=%h done=%b, want fffe0001 0", result, done);
        end
    endtask

    task automatic test_abort();
        drive(1'b1, 3'd5, 16'h1234, 16'h0010);
        tick();
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_busy8: busy=%b, want 1", busy);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_clr: result=%h zero=%b busy=%b done=%b, want 0 1 0 0",
                     result, zero, busy, done);
        end
        drive(1'b1, 3'd1, 16'h0001, 16'h0002);
        tick();
        drive(1'b0, 3'd0, '0, '0);
        n_checks++;
        if (result !== 32'h3 || done !== 1'b1 || zero !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_or: result=%h done=%b zero=%b, want 00000003 1 0",
                     result, done, zero);
        end
        for (int i = 0; i < DW + 2; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || result !== 32'h3) begin
                n_errors++;
                $display("FAIL abort_late[%0d]: done=%b result=%h, want 0 00000003",
                         i, done, result);
            end
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 3'd2, 16'h1357, 16'h2468);
        tick();
        drive(1'b1, 3'd1, 16'hFFFF, 16'hFFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        n_checks++;
        if (result !== '0 || done !== 1'b0 || zero !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_clr_ctrl: result=%h done=%b zero=%b, want 0 0 1",
                     result, done, zero);
        end
        drive(1'b1, 3'd1, 16'h00A0, 16'h0005);
        tick();
        drive(1'b1, 3'd5, 16'h0003, 16'h0007);
        tick();
        drive(1'b0, 3'd0, '0, '0);
        tick();
        tick();
        hreset = 1'b1;
        tick();
        n_checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_reset_mul: result=%h done=%b busy=%b zero=%b, want 0 0 0 1",
                     result, done, busy, zero);
        end
        hreset = 1'b0;
        for (int i = 0; i < DW + 2; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
                n_errors++;
                $display("FAIL prio_reset_quiet[%0d]: done=%b busy=%b result=%h, want 0 0 0",
                         i, done, busy, result);
            end
        end
    endtask

    // Reference: result changes only on a completed op or clear; a multiply
    // occupies exactly DW further edges and then lands its full product.
    task automatic test_random();
        logic [RW-1:0] m_res;
        logic          m_done;
        logic          m_pend;
        int            m_rem;
        logic [RW-1:0] m_prod;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        hreset = 1'b1;
        drive(1'b0, 3'd0, '0, '0);
        tick();
        hreset = 1'b0;
        m_res = '0;
        m_done = 1'b0;
        m_pend = 1'b0;
        m_rem = 0;
        m_prod = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            a = 16'($urandom());
            b = 16'($urandom());
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) b = b & 16'h000F;
            drive($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), a, b);
            clr = ($urandom_range(0, 39) == 0);
            if (clr) begin
                m_res = '0;
                m_pend = 1'b0;
                m_done = 1'b0;
            end else if (m_pend) begin
                m_rem--;
                m_done = (m_rem == 0);
                if (m_rem == 0) begin
                    m_res = m_prod;
                    m_pend = 1'b0;
                end
            end else if (ctrl) begin
                if (mode == 3'd5) begin
                    m_pend = 1'b1;
                    m_rem = DW;
                    m_prod = ref_op(mode, a, b);
                    m_done = 1'b0;
                end else begin
                    m_res = ref_op(mode, a, b);
                    m_done = 1'b1;
                end
            end else begin
                m_done = 1'b0;
            end
            tick();
            n_checks++;
            if (result !== m_res || done !== m_done || busy !== m_pend ||
                zero !== (m_res == '0)) begin
                n_errors++;
                $display("FAIL random[%0d]: result=%h done=%b busy=%b zero=%b, want %h %b %b %b",
                         cyc, result, done, busy, zero, m_res, m_done, m_pend, m_res == '0);
            end
            n_checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                n_errors++;
                $display("FAIL random_busy_done[%0d]: busy=%b done=%b, want not both 1",
                         cyc, busy, done);
            end
        end
        clr = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sub_shift();
        test_mul();
        test_abort();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
